// File: rtl/pyjamask96_ctrl.sv
// rtl/pyjamask96_ctrl.sv - sequencer wrapping the byte-serial pyjamask96 core
//
// Accepts one 96-bit block plus 128-bit key, streams them into the core over
// 16 load cycles, pulses start, waits for the core's valid, deserialises the
// 12 ciphertext bytes and presents the 96-bit result on a valid/ready port.
//
// Ports:
//   clk, reset                    rising-edge clock, async active-high reset
//   in_valid/in_ready             request handshake, in_block (96b), in_key (128b)
//   out_valid/out_ready           result handshake, out_block (96b)
//   busy                          high in any state other than IDLE
//   error                         sticky timeout / truncated-output flag
//   core_reset_n                  ~reset, active-low reset for the core
//   core_load, core_start         core control strobes
//   core_byte_in/core_byte_key_in byte-serial block / key into the core
//   core_valid, core_byte_out     byte-serial result from the core
// Byte 0 of every wide bus is its most significant byte.

module pyjamask96_ctrl #(
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [95:0]  in_block,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [95:0]  out_block,
  output logic         busy,
  output logic         error,
  output logic         core_reset_n,
  output logic         core_load,
  output logic         core_start,
  output logic [7:0]   core_byte_in,
  output logic [7:0]   core_byte_key_in,
  input  logic         core_valid,
  input  logic [7:0]   core_byte_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_START,
    S_WAIT,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t         state;

  // Shadow registers double as shift registers: they hold the bytes still to
  // be sent, MSB first. The block register empties after byte 11, which
  // naturally yields the four trailing 8'h00 load bytes.
  logic [95:0]    blk_sh;
  logic [127:0]   key_sh;

  logic [3:0]     load_cnt;
  logic [2:0]     start_cnt;
  logic [15:0]    wait_cnt;
  logic [3:0]     byte_cnt;

  assign core_reset_n = ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      in_ready         <= 1'b1;
      out_valid        <= 1'b0;
      out_block        <= '0;
      busy             <= 1'b0;
      error            <= 1'b0;
      core_load        <= 1'b0;
      core_start       <= 1'b0;
      core_byte_in     <= 8'h00;
      core_byte_key_in <= 8'h00;
      blk_sh           <= '0;
      key_sh           <= '0;
      load_cnt         <= '0;
      start_cnt        <= '0;
      wait_cnt         <= '0;
      byte_cnt         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            // Byte 0 goes straight onto the buses; the rest wait in the shadows.
            core_byte_in     <= in_block[95:88];
            core_byte_key_in <= in_key[127:120];
            blk_sh           <= {in_block[87:0], 8'h00};
            key_sh           <= {in_key[119:0], 8'h00};
            core_load        <= 1'b1;
            load_cnt         <= 4'd0;
            in_ready         <= 1'b0;
            busy             <= 1'b1;
            error            <= 1'b0;
            state            <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (load_cnt == 4'd15) begin
            core_load        <= 1'b0;
            core_byte_in     <= 8'h00;
            core_byte_key_in <= 8'h00;
            state            <= S_GAP;
          end else begin
            load_cnt         <= load_cnt + 4'd1;
            core_byte_in     <= blk_sh[95:88];
            core_byte_key_in <= key_sh[127:120];
            blk_sh           <= {blk_sh[87:0], 8'h00};
            key_sh           <= {key_sh[119:0], 8'h00};
          end
        end

        S_GAP: begin
          core_start <= 1'b1;
          start_cnt  <= 3'd0;
          state      <= S_START;
        end

        S_START: begin
          if (start_cnt == 3'(START_CYCLES - 1)) begin
            core_start <= 1'b0;
            wait_cnt   <= 16'd0;
            state      <= S_WAIT;
          end else begin
            start_cnt <= start_cnt + 3'd1;
          end
        end

        S_WAIT: begin
          wait_cnt <= wait_cnt + 16'd1;
          if (core_valid) begin
            out_block <= {out_block[87:0], core_byte_out};
            byte_cnt  <= 4'd1;
            state     <= S_COLLECT;
          end else if (wait_cnt == 16'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th WAIT cycle without a response.
            error    <= 1'b1;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end

        S_COLLECT: begin
          if (!core_valid) begin
            error    <= 1'b1;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            out_block <= {out_block[87:0], core_byte_out};
            if (byte_cnt == 4'd11) begin
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
